// File: rtl/pong_pkg.sv
// Shared pong definitions: ball FSM encodings, direction constants and geometry defaults.
package pong_pkg;

    localparam int COORD_W          = 10;
    localparam int DEF_BALL_SIZE    = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        MOVE       = 2'd2,
        SCORED     = 2'd3
    } ball_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/ball_tick_gen.sv
// Free-running divider: tick_o is high for the one cycle where the counter sits at STEP_DIV-1.
module ball_tick_gen #(
    parameter int STEP_DIV = 500000
) (
    input  logic CLK_100MHz,
    input  logic Reset,
    output logic tick_o
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ball_motion.sv
// Pong ball engine: moves an 8x8 box per tick, bounces off walls/paddles, pulses score on a miss.
// Optional BALL_SPEEDUP_EN: each paddle hit adds one pixel of step, saturating at 2*STEP.
module ball_motion
    import pong_pkg::*;
#(
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int STEP        = 2,
    parameter int STEP_DIV    = 500000,
    parameter int SERVE_TICKS = 50,
    parameter int START_H     = 316,
    parameter int START_V     = 236
) (
    input  logic       CLK_100MHz,
    input  logic       Reset,
    input  logic [9:0] padLHmin,
    input  logic [9:0] padLHmax,
    input  logic [9:0] padLVmin,
    input  logic [9:0] padLVmax,
    input  logic [9:0] padRHmin,
    input  logic [9:0] padRHmax,
    input  logic [9:0] padRVmin,
    input  logic [9:0] padRVmax,
    input  logic [9:0] borderHmin,
    input  logic [9:0] borderHmax,
    input  logic [9:0] borderVmin,
    input  logic [9:0] borderVmax,
    input  logic       Serve,
    output logic [9:0] Hmin,
    output logic [9:0] Hmax,
    output logic [9:0] Vmin,
    output logic [9:0] Vmax,
    output logic       scoreL,
    output logic       scoreR,
    output logic       dirH,
    output logic       dirV,
    output logic [1:0] state
);

    localparam int W  = COORD_W;
    localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [W-1:0]  SZ    = W'(BALL_SIZE);
    localparam logic [W-1:0]  SZ1   = W'(BALL_SIZE - 1);
    localparam logic [W-1:0]  ONE   = W'(1);
    localparam logic [W-1:0]  STEPW = W'(STEP);
    localparam logic [W-1:0]  CTR_H = W'(START_H);
    localparam logic [W-1:0]  CTR_V = W'(START_V);
    localparam logic [SW-1:0] SRV_LAST = SW'(SERVE_TICKS - 1);

    ball_state_e   state_q, state_d;
    logic [W-1:0]  hmin_q, hmin_d, hmax_q, vmin_q, vmin_d, vmax_q;
    logic          dirh_q, dirh_d, dirv_q, dirv_d;
    logic          scl_q, scl_d, scr_q, scr_d;
    logic [SW-1:0] srv_q, srv_d;
    logic [W-1:0]  s;
    logic          tick, hit, miss, ovl, ovr;

    ball_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
        .CLK_100MHz (CLK_100MHz),
        .Reset      (Reset),
        .tick_o     (tick)
    );

    assign ovl = (vmax_q >= padLVmin) && (vmin_q <= padLVmax);
    assign ovr = (vmax_q >= padRVmin) && (vmin_q <= padRVmax);

    always_comb begin
        state_d = state_q;
        hmin_d  = hmin_q;
        vmin_d  = vmin_q;
        dirh_d  = dirh_q;
        dirv_d  = dirv_q;
        scl_d   = 1'b0;
        scr_d   = 1'b0;
        srv_d   = srv_q;
        hit     = 1'b0;
        miss    = 1'b0;
        case (state_q)
            IDLE: begin
                hmin_d = CTR_H;
                vmin_d = CTR_V;
                srv_d  = '0;
                if (Serve) state_d = SERVE_WAIT;
            end
            SERVE_WAIT: begin
                if (tick) begin
                    if (srv_q == SRV_LAST) begin
                        srv_d   = '0;
                        state_d = MOVE;
                    end else begin
                        srv_d = srv_q + SW'(1);
                    end
                end
            end
            MOVE: begin
                if (tick) begin
                    if (dirv_q == DIR_DOWN) begin
                        if (vmax_q + s >= borderVmax) begin
                            vmin_d = borderVmax - SZ1;
                            dirv_d = DIR_UP;
                        end else begin
                            vmin_d = vmin_q + s;
                        end
                    end else if (vmin_q <= borderVmin + s) begin
                        vmin_d = borderVmin;
                        dirv_d = DIR_DOWN;
                    end else begin
                        vmin_d = vmin_q - s;
                    end
                    // Thresholds add s to the fixed side so nothing underflows.
                    if (dirh_q == DIR_LEFT) begin
                        if (hmin_q > padLHmax && hmin_q <= padLHmax + s && ovl) begin
                            hmin_d = padLHmax + ONE;
                            dirh_d = DIR_RIGHT;
                            hit    = 1'b1;
                        end else if (hmin_q <= borderHmin + s) begin
                            miss   = 1'b1;
                            scr_d  = 1'b1;
                            dirh_d = DIR_LEFT;
                        end else begin
                            hmin_d = hmin_q - s;
                        end
                    end else begin
                        if (hmax_q < padRHmin && hmax_q + s >= padRHmin && ovr) begin
                            hmin_d = padRHmin - SZ;
                            dirh_d = DIR_LEFT;
                            hit    = 1'b1;
                        end else if (hmax_q + s >= borderHmax) begin
                            miss   = 1'b1;
                            scl_d  = 1'b1;
                            dirh_d = DIR_RIGHT;
                        end else begin
                            hmin_d = hmin_q + s;
                        end
                    end
                    if (miss) begin
                        state_d = SCORED;
                        hmin_d  = CTR_H;
                        vmin_d  = CTR_V;
                        dirv_d  = DIR_DOWN;
                    end
                end
            end
            SCORED:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef BALL_SPEEDUP_EN
    logic [W-1:0] s_q, s_d;

    always_comb begin
        s_d = s_q;
        if (miss)                          s_d = STEPW;
        else if (hit && s_q < W'(2 * STEP)) s_d = s_q + ONE;
    end

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) s_q <= STEPW;
        else       s_q <= s_d;
    end

    assign s = s_q;
`else
    logic unused_hit;
    assign unused_hit = hit;
    assign s = STEPW;
`endif

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            hmin_q  <= CTR_H;
            hmax_q  <= CTR_H + SZ1;
            vmin_q  <= CTR_V;
            vmax_q  <= CTR_V + SZ1;
            dirh_q  <= DIR_RIGHT;
            dirv_q  <= DIR_DOWN;
            scl_q   <= 1'b0;
            scr_q   <= 1'b0;
            srv_q   <= '0;
        end else begin
            state_q <= state_d;
            hmin_q  <= hmin_d;
            hmax_q  <= hmin_d + SZ1;
            vmin_q  <= vmin_d;
            vmax_q  <= vmin_d + SZ1;
            dirh_q  <= dirh_d;
            dirv_q  <= dirv_d;
            scl_q   <= scl_d;
            scr_q   <= scr_d;
            srv_q   <= srv_d;
        end
    end

    assign Hmin   = hmin_q;
    assign Hmax   = hmax_q;
    assign Vmin   = vmin_q;
    assign Vmax   = vmax_q;
    assign dirH   = dirh_q;
    assign dirV   = dirv_q;
    assign scoreL = scl_q;
    assign scoreR = scr_q;
    assign state  = state_q;

endmodule
